// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the 8N1 UART receiver and transmitter.
//   - Default line rate and system clock frequency.
//   - Constant functions for the bit period and the half bit period.
//   - Frame shape: 8 data bits, 1 stop bit, no parity.
//   - Receiver state encoding.
package uart_pkg;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int BAUD_DEF     = 115200;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Clocks per bit on the line. Uses integer division, so a fractional
  // bit period is truncated. Mid-bit sampling absorbs the resulting
  // rate error.
  function automatic int bitClks(input int clkFreq, input int baud);
    return clkFreq / baud;
  endfunction

  // Clocks from detecting the start edge to the middle of the start bit.
  function automatic int halfClks(input int bitPeriod);
    return bitPeriod / 2;
  endfunction

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rxState_t;

endpackage

// File: rtl/uart_sync.sv
// uart_sync
// Two-flop synchronizer for asynchronous inputs. Both flops reset to
// RST_VAL, so a line that idles high does not show a false edge when
// reset is released.
//   i_Clk   in   destination clock
//   i_Rst   in   synchronous, active-high reset
//   i_Async in   asynchronous input, WIDTH bits
//   o_Sync  out  synchronized copy, delayed by two clocks
module uart_sync #(
  parameter int       WIDTH   = 1,
  parameter bit       RST_VAL = 1'b1
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [WIDTH-1:0] i_Async,
  output logic [WIDTH-1:0] o_Sync
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      meta <= {WIDTH{RST_VAL}};
      sync <= {WIDTH{RST_VAL}};
    end else begin
      meta <= i_Async;
      sync <= meta;
    end
  end

  assign o_Sync = sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 UART receiver. Bits arrive LSB first. Each bit is sampled at its
// middle. The block counts HALF_CLKS clocks from the start edge, and
// after that it counts BIT_CLKS clocks per bit.
//   i_Clk       in   system clock, rising edge
//   i_Rst       in   synchronous, active-high reset
//   i_Rx        in   asynchronous serial line, idle high
//   i_fAck      in   consumer took o_Data; clears o_fValid
//   o_Data      out  last correctly framed byte
//   o_fValid    out  o_Data holds a byte that is not yet acknowledged
//   o_fDone     out  one-cycle pulse for each good frame
//   o_fFrameErr out  one-cycle pulse when the stop bit is sampled low
//   o_fOverrun  out  one-cycle pulse when a good frame lands on an
//                    unacknowledged byte
//   o_fBusy     out  FSM is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = CLK_FREQ_DEF,
  parameter int BAUD      = BAUD_DEF,
  parameter int BIT_CLKS  = bitClks(CLK_FREQ, BAUD),
  parameter int HALF_CLKS = halfClks(BIT_CLKS)
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Rx,
  input  logic                 i_fAck,
  output logic [DATA_BITS-1:0] o_Data,
  output logic                 o_fValid,
  output logic                 o_fDone,
  output logic                 o_fFrameErr,
  output logic                 o_fOverrun,
  output logic                 o_fBusy
);

  localparam int CNT_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CLKS - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 rxS;
  rxState_t             state;
  logic [CNT_W-1:0]     ClkCnt;
  logic [2:0]           BitCnt;
  logic [DATA_BITS-1:0] Shift;

  uart_sync #(
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_sync (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Async(i_Rx),
    .o_Sync (rxS)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state       <= RX_IDLE;
      ClkCnt      <= '0;
      BitCnt      <= '0;
      Shift       <= '0;
      o_Data      <= '0;
      o_fValid    <= 1'b0;
      o_fDone     <= 1'b0;
      o_fFrameErr <= 1'b0;
      o_fOverrun  <= 1'b0;
      o_fBusy     <= 1'b0;
    end else begin
      o_fDone     <= 1'b0;
      o_fFrameErr <= 1'b0;
      o_fOverrun  <= 1'b0;

      // An ack clears the byte. A frame that completes in the same cycle
      // overrides this below, so the new byte is never lost.
      if (i_fAck) o_fValid <= 1'b0;

      case (state)
        RX_IDLE: begin
          ClkCnt <= '0;
          if (!rxS) begin
            state   <= RX_START;
            o_fBusy <= 1'b1;
          end
        end

        // Re-check the line at mid-start. A pulse shorter than half a
        // bit is treated as noise and dropped without any output.
        RX_START: begin
          if (ClkCnt == HALF_LAST) begin
            ClkCnt <= '0;
            if (!rxS) begin
              state  <= RX_DATA;
              BitCnt <= '0;
            end else begin
              state   <= RX_IDLE;
              o_fBusy <= 1'b0;
            end
          end else begin
            ClkCnt <= ClkCnt + CNT_W'(1);
          end
        end

        RX_DATA: begin
          if (ClkCnt == BIT_LAST) begin
            ClkCnt <= '0;
            Shift  <= {rxS, Shift[DATA_BITS-1:1]};
            BitCnt <= BitCnt + 3'd1;
            if (BitCnt == LAST_BIT) state <= RX_STOP;
          end else begin
            ClkCnt <= ClkCnt + CNT_W'(1);
          end
        end

        RX_STOP: begin
          if (ClkCnt == BIT_LAST) begin
            ClkCnt <= '0;
            if (rxS) begin
              o_Data     <= Shift;
              o_fDone    <= 1'b1;
              o_fValid   <= 1'b1;
              o_fOverrun <= o_fValid & ~i_fAck;
              state      <= RX_IDLE;
              o_fBusy    <= 1'b0;
            end else begin
              o_fFrameErr <= 1'b1;
              state       <= RX_BREAK;
            end
          end else begin
            ClkCnt <= ClkCnt + CNT_W'(1);
          end
        end

        // A line held low after a bad stop bit must not be read as a
        // string of 0x00 frames. Wait for it to return to idle.
        RX_BREAK: begin
          ClkCnt <= '0;
          if (rxS) begin
            state   <= RX_IDLE;
            o_fBusy <= 1'b0;
          end
        end

        default: begin
          state   <= RX_IDLE;
          ClkCnt  <= '0;
          o_fBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int BIT       = 434;
  localparam int HALF      = 217;
  localparam int STOP_EDGE = 2 + HALF + 9 * BIT;  // 4125

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid, done, ferr, ovr, busy;

  always #5 clk = ~clk;

  uart_rx dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Rx       (rx),
    .i_fAck     (ack),
    .o_Data     (data),
    .o_fValid   (valid),
    .o_fDone    (done),
    .o_fFrameErr(ferr),
    .o_fOverrun (ovr),
    .o_fBusy    (busy)
  );

  // Edge counter: after rising edge n, cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Pulse monitor. It counts the cycles in which each pulse is high and
  // records the edge that raised the pulse.
  int nDone = 0, nFerr = 0, nOvr = 0;
  int lastDone = -1, lastFerr = -1, lastOvr = -1;
  always @(negedge clk) begin
    if (done) begin nDone++; lastDone = cyc; end
    if (ferr) begin nFerr++; lastFerr = cyc; end
    if (ovr)  begin nOvr++;  lastOvr  = cyc; end
  end

  int nChecks = 0, nFail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Call #1 after a rising edge. The start bit goes out on the next edge,
  // which is t0. The task returns #1 after the last edge of the stop bit
  // and leaves the line at the stop value.
  task automatic sendFrame(input logic [7:0] d, input logic stopBit, output int t0);
    t0 = cyc + 1;
    rx = 1'b0;
    repeat (BIT) @(posedge clk);
    #1;
    for (int b = 0; b < 8; b++) begin
      rx = d[b];
      repeat (BIT) @(posedge clk);
      #1;
    end
    rx = stopBit;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic doAck();
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stopBit;
    logic       ackBefore;
    logic [7:0] expData;
    logic       expValid;
    int         expDone;
    int         expFerr;
    int         expOvr;
  } vec_t;

  vec_t vecs[7];

  int t0, d0, f0, o0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1, 0, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1, 0, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1, 0, 0};
    vecs[3] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1, 0, 0};
    vecs[4] = '{8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1, 0, 1};
    vecs[5] = '{8'h3C, 1'b0, 1'b0, 8'h22, 1'b1, 0, 1, 0};
    vecs[6] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1, 0, 0};

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_done", done, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_busy", busy, 0);
    repeat (5) @(posedge clk);
    #1;

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].ackBefore) begin
        doAck();
        chk("ack_clears_valid", valid, 0);
      end
      d0 = nDone; f0 = nFerr; o0 = nOvr;
      sendFrame(vecs[i].d, vecs[i].stopBit, t0);
      if (!vecs[i].stopBit) begin
        chk("break_busy", busy, 1);
        repeat (2000) @(posedge clk);
        #1;
        chk("break_held_busy", busy, 1);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("break_release_idle", busy, 0);
      end
      chk("vec_data", data, vecs[i].expData);
      chk("vec_valid", valid, vecs[i].expValid);
      chk("vec_done_cnt", nDone - d0, vecs[i].expDone);
      chk("vec_ferr_cnt", nFerr - f0, vecs[i].expFerr);
      chk("vec_ovr_cnt", nOvr - o0, vecs[i].expOvr);
      if (vecs[i].expDone != 0) chk("vec_done_time", lastDone, t0 + STOP_EDGE);
      if (vecs[i].expFerr != 0) chk("vec_ferr_time", lastFerr, t0 + STOP_EDGE);
      if (vecs[i].expOvr != 0)  chk("vec_ovr_time", lastOvr, t0 + STOP_EDGE);
    end

    // Ack lands on the done edge of a new frame: no overrun, still valid
    d0 = nDone; o0 = nOvr;
    fork
      sendFrame(8'h44, 1'b1, t0);
      begin
        repeat (STOP_EDGE) @(posedge clk);
        #1;
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
      end
    join
    chk("ackdone_done_cnt", nDone - d0, 1);
    chk("ackdone_ovr_cnt", nOvr - o0, 0);
    chk("ackdone_valid", valid, 1);
    chk("ackdone_data", data, 8'h44);

    // 100-cycle glitch on an idle line
    d0 = nDone; f0 = nFerr;
    rx = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rx = 1'b1;
    chk("glitch_busy", busy, 1);
    repeat (120) @(posedge clk);
    #1;
    chk("glitch_idle", busy, 0);
    chk("glitch_done_cnt", nDone - d0, 0);
    chk("glitch_ferr_cnt", nFerr - f0, 0);
    repeat (10) @(posedge clk);
    #1;

    // Reset during data bit 4. The remaining bits of 0xF3 are all 1, so
    // the tail of the aborted frame cannot look like a new start edge.
    d0 = nDone;
    fork
      sendFrame(8'hF3, 1'b1, t0);
      begin
        repeat (2300) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_data", data, 8'h00);
        chk("midrst_valid", valid, 0);
        chk("midrst_busy", busy, 0);
      end
    join
    chk("midrst_no_done", nDone - d0, 0);
    chk("midrst_idle", busy, 0);

    d0 = nDone;
    sendFrame(8'h5A, 1'b1, t0);
    chk("post_rst_data", data, 8'h5A);
    chk("post_rst_valid", valid, 1);
    chk("post_rst_done_cnt", nDone - d0, 1);
    chk("post_rst_done_time", lastDone, t0 + STOP_EDGE);
    doAck();
    chk("final_ack_valid", valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
